// File: rtl/axi_pack.sv
// Shared AXI4-Lite definitions: response encodings, prot bit positions and the
// byte-strobe merge helper used by register-file style slaves.
package axi_pack;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

   localparam int PROT_PRIV  = 0;
   localparam int PROT_NSEC  = 1;
   localparam int PROT_INSTR = 2;

   // Sized for the widest legal bus; narrower callers zero-extend and truncate.
   function automatic logic [63:0] strb_merge(input logic [63:0] oldWord,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  wstrb);
      logic [63:0] merged;
      merged = oldWord;
      for (int b = 0; b < 8; b++) begin
         if (wstrb[b]) begin
            merged[8*b +: 8] = wdata[8*b +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface AXI4_LITE #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                      awvalid;
   logic                      awready;
   logic [ADDR_WIDTH-1:0]     awaddr;
   logic [2:0]                awprot;
   logic                      wvalid;
   logic                      wready;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH/8-1:0]   wstrb;
   logic                      bvalid;
   logic                      bready;
   logic [1:0]                bresp;
   logic                      arvalid;
   logic                      arready;
   logic [ADDR_WIDTH-1:0]     araddr;
   logic [2:0]                arprot;
   logic                      rvalid;
   logic                      rready;
   logic [DATA_WIDTH-1:0]     rdata;
   logic [1:0]                rresp;

   modport SLAVE (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      input  arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport MASTER (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      output arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file with independent write/read FSMs.
// Optional macro AXI_LITE_REGFILE_PROT_CHECK_EN rejects unprivileged accesses.
module axi_lite_regfile
   import axi_pack::*;
#(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    NUM_REGS   = 16,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   AXI4_LITE.SLAVE                        s_axi,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
   output logic [NUM_REGS-1:0]            wr_pulse_o
);

   localparam int OFFS  = $clog2(DATA_WIDTH / 8);
   localparam int IDXW  = ADDR_WIDTH - OFFS;
   localparam int STRBW = DATA_WIDTH / 8;

   typedef enum logic {W_IDLE, W_RESP} wState_t;
   typedef enum logic {R_IDLE, R_DATA} rState_t;

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
   logic [NUM_REGS-1:0]   r_wrPulse;

   wState_t               r_wState, w_wStateNext;
   logic                  r_awHeld, r_wHeld, r_awPriv;
   logic [IDXW-1:0]       r_awIdx;
   logic [DATA_WIDTH-1:0] r_wData;
   logic [STRBW-1:0]      r_wStrb;
   resp_t                 r_bResp;

   rState_t               r_rState, w_rStateNext;
   logic [DATA_WIDTH-1:0] r_rData;
   resp_t                 r_rResp;

   logic                  w_awFire, w_wFire, w_arFire, w_commit, w_wrAllowed, w_wrEn;
   logic                  w_awPriv, w_arPriv, w_wrPriv, w_rdAllowed;
   logic [IDXW-1:0]       w_wrIdx, w_rdIdx;
   logic [DATA_WIDTH-1:0] w_wrData, w_rdWord;
   logic [STRBW-1:0]      w_wrStrb;
   logic                  w_unusedBits;

`ifdef AXI_LITE_REGFILE_PROT_CHECK_EN
   assign w_awPriv     = s_axi.awprot[PROT_PRIV];
   assign w_arPriv     = s_axi.arprot[PROT_PRIV];
   assign w_unusedBits = ^{s_axi.awaddr[OFFS-1:0], s_axi.araddr[OFFS-1:0],
                           s_axi.awprot[PROT_INSTR], s_axi.awprot[PROT_NSEC],
                           s_axi.arprot[PROT_INSTR], s_axi.arprot[PROT_NSEC]};
`else
   assign w_awPriv     = 1'b1;
   assign w_arPriv     = 1'b1;
   assign w_unusedBits = ^{s_axi.awaddr[OFFS-1:0], s_axi.araddr[OFFS-1:0],
                           s_axi.awprot, s_axi.arprot};
`endif

   assign s_axi.awready = (r_wState == W_IDLE) && !r_awHeld;
   assign s_axi.wready  = (r_wState == W_IDLE) && !r_wHeld;
   assign s_axi.bvalid  = (r_wState == W_RESP);
   assign s_axi.bresp   = r_bResp;
   assign s_axi.arready = (r_rState == R_IDLE);
   assign s_axi.rvalid  = (r_rState == R_DATA);
   assign s_axi.rdata   = r_rData;
   assign s_axi.rresp   = r_rResp;

   assign w_awFire = s_axi.awvalid && s_axi.awready;
   assign w_wFire  = s_axi.wvalid && s_axi.wready;
   assign w_arFire = s_axi.arvalid && s_axi.arready;

   // A side captured in an earlier cycle wins over the live bus value.
   always_comb begin
      w_wrIdx      = r_awHeld ? r_awIdx  : s_axi.awaddr[ADDR_WIDTH-1:OFFS];
      w_wrPriv     = r_awHeld ? r_awPriv : w_awPriv;
      w_wrData     = r_wHeld  ? r_wData  : s_axi.wdata;
      w_wrStrb     = r_wHeld  ? r_wStrb  : s_axi.wstrb;
      w_commit     = 1'b0;
      w_wStateNext = r_wState;
      case (r_wState)
         W_IDLE: begin
            if ((r_awHeld || w_awFire) && (r_wHeld || w_wFire)) begin
               w_commit     = 1'b1;
               w_wStateNext = W_RESP;
            end
         end
         W_RESP: begin
            if (s_axi.bready) begin
               w_wStateNext = W_IDLE;
            end
         end
         default: w_wStateNext = W_IDLE;
      endcase
   end

   assign w_wrAllowed = ({1'b0, w_wrIdx} < (IDXW+1)'(NUM_REGS)) && w_wrPriv;
   assign w_wrEn      = w_commit && w_wrAllowed;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_wState <= W_IDLE;
         r_awHeld <= 1'b0;
         r_wHeld  <= 1'b0;
         r_awIdx  <= '0;
         r_awPriv <= 1'b0;
         r_wData  <= '0;
         r_wStrb  <= '0;
         r_bResp  <= RESP_OKAY;
      end else begin
         r_wState <= w_wStateNext;
         if (w_commit) begin
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
            r_bResp  <= w_wrAllowed ? RESP_OKAY : RESP_SLVERR;
         end else begin
            if (w_awFire) begin
               r_awHeld <= 1'b1;
               r_awIdx  <= s_axi.awaddr[ADDR_WIDTH-1:OFFS];
               r_awPriv <= w_awPriv;
            end
            if (w_wFire) begin
               r_wHeld <= 1'b1;
               r_wData <= s_axi.wdata;
               r_wStrb <= s_axi.wstrb;
            end
         end
      end
   end

   always_ff @(posedge aclk) begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (!aresetn) begin
            r_regs[i]    <= RESET_VAL;
            r_wrPulse[i] <= 1'b0;
         end else begin
            r_wrPulse[i] <= w_wrEn && (w_wrIdx == IDXW'(i));
            if (w_wrEn && (w_wrIdx == IDXW'(i))) begin
               r_regs[i] <= DATA_WIDTH'(strb_merge(64'(r_regs[i]), 64'(w_wrData), 8'(w_wrStrb)));
            end
         end
      end
   end

   assign w_rdIdx     = s_axi.araddr[ADDR_WIDTH-1:OFFS];
   assign w_rdAllowed = ({1'b0, w_rdIdx} < (IDXW+1)'(NUM_REGS)) && w_arPriv;

   always_comb begin
      w_rdWord = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_rdIdx == IDXW'(i)) begin
            w_rdWord = r_regs[i];
         end
      end
   end

   always_comb begin
      w_rStateNext = r_rState;
      case (r_rState)
         R_IDLE:  if (w_arFire)     w_rStateNext = R_DATA;
         R_DATA:  if (s_axi.rready) w_rStateNext = R_IDLE;
         default: w_rStateNext = R_IDLE;
      endcase
   end

   // Read data is sampled from the registered array, so a same-edge write is not visible.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_rState <= R_IDLE;
         r_rData  <= '0;
         r_rResp  <= RESP_OKAY;
      end else begin
         r_rState <= w_rStateNext;
         if (w_arFire) begin
            r_rData <= w_rdAllowed ? w_rdWord : '0;
            r_rResp <= w_rdAllowed ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
   end
   assign wr_pulse_o = r_wrPulse;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Scoreboard bench for axi_lite_regfile: stimulus pushes expected B/R responses,
// a monitor pops and compares on every handshake. Honours AXI_LITE_REGFILE_PROT_CHECK_EN.
module tb_axi_lite_regfile;

   logic         aclk;
   logic         aresetn;
   logic [511:0] regsO;
   logic [15:0]  wrPulseO;

   int           checkCount = 0;
   int           passCount  = 0;
   logic [1:0]   expB[$];
   logic [33:0]  expR[$];
   logic [31:0]  model[16];

   AXI4_LITE #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

   axi_lite_regfile #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(32),
      .NUM_REGS(16),
      .RESET_VAL('0)
   ) dut (
      .aclk(aclk),
      .aresetn(aresetn),
      .s_axi(bus),
      .regs_o(regsO),
      .wr_pulse_o(wrPulseO)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic timeoutFail(input string name);
      checkCount++;
      $display("[TB] FAIL %s: timed out, got no handshake, expected one", name);
   endtask

   task automatic checkRegs(input string tag);
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("%s_reg%0d", tag, i), 64'(regsO[i*32 +: 32]), 64'(model[i]));
      end
   endtask

   // Monitor: one handshake per negedge with valid&&ready.
   initial begin
      logic [1:0]  eb;
      logic [33:0] er;
      forever begin
         @(negedge aclk);
         if (bus.bvalid && bus.bready) begin
            if (expB.size() == 0) begin
               checkCount++;
               $display("[TB] FAIL unexpectedB: got bresp 0x%0h, expected no response", bus.bresp);
            end else begin
               eb = expB.pop_front();
               checkOutput("bresp", 64'(bus.bresp), 64'(eb));
            end
         end
         if (bus.rvalid && bus.rready) begin
            if (expR.size() == 0) begin
               checkCount++;
               $display("[TB] FAIL unexpectedR: got rdata 0x%0h, expected no response", bus.rdata);
            end else begin
               er = expR.pop_front();
               checkOutput("rresp", 64'(bus.rresp), 64'(er[33:32]));
               checkOutput("rdata", 64'(bus.rdata), 64'(er[31:0]));
            end
         end
      end
   end

   task automatic sendAw(input logic [7:0] addr, input logic [2:0] prot);
      bit done = 0;
      bus.awaddr  = addr;
      bus.awprot  = prot;
      bus.awvalid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge aclk);
         if (bus.awready) begin
            @(posedge aclk); #1;
            bus.awvalid = 1'b0;
            done = 1;
         end
      end
      if (!done) begin
         bus.awvalid = 1'b0;
         timeoutFail("awHandshake");
      end
   endtask

   task automatic sendW(input logic [31:0] data, input logic [3:0] strb);
      bit done = 0;
      bus.wdata  = data;
      bus.wstrb  = strb;
      bus.wvalid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge aclk);
         if (bus.wready) begin
            @(posedge aclk); #1;
            bus.wvalid = 1'b0;
            done = 1;
         end
      end
      if (!done) begin
         bus.wvalid = 1'b0;
         timeoutFail("wHandshake");
      end
   endtask

   task automatic sendAr(input logic [7:0] addr, input logic [2:0] prot);
      bit done = 0;
      bus.araddr  = addr;
      bus.arprot  = prot;
      bus.arvalid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge aclk);
         if (bus.arready) begin
            @(posedge aclk); #1;
            bus.arvalid = 1'b0;
            done = 1;
         end
      end
      if (!done) begin
         bus.arvalid = 1'b0;
         timeoutFail("arHandshake");
      end
   endtask

   // AW and W presented in the same cycle; returns one step after the commit edge.
   task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                input logic [2:0] prot, input logic [1:0] resp);
      expB.push_back(resp);
      fork
         sendAw(addr, prot);
         sendW(data, strb);
      join
      checkOutput("bvalidAfterCommit", 64'(bus.bvalid), 64'(1));
   endtask

   task automatic readReg(input logic [7:0] addr, input logic [2:0] prot, input logic [1:0] resp,
                          input logic [31:0] data);
      expR.push_back({resp, data});
      sendAr(addr, prot);
      checkOutput("rvalidLatency", 64'(bus.rvalid), 64'(1));
   endtask

   task automatic drainResponses();
      bit done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (expB.size() == 0 && expR.size() == 0) done = 1;
         else begin
            @(posedge aclk); #1;
         end
      end
      if (!done) timeoutFail("drainResponses");
   endtask

   initial begin
      bus.awvalid = 0; bus.awaddr = '0; bus.awprot = 3'b001;
      bus.wvalid  = 0; bus.wdata  = '0; bus.wstrb  = '0;
      bus.arvalid = 0; bus.araddr = '0; bus.arprot = 3'b001;
      bus.bready  = 1; bus.rready = 1;
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
      aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      aresetn = 1'b1;

      checkOutput("resetReadies", 64'({bus.awready, bus.wready, bus.arready}), 64'(3'b111));
      checkOutput("resetValids", 64'({bus.bvalid, bus.rvalid}), 64'(2'b00));
      checkOutput("resetResps", 64'({bus.bresp, bus.rresp}), 64'(4'b0000));
      checkOutput("resetRdata", 64'(bus.rdata), 64'(0));
      checkOutput("resetPulse", 64'(wrPulseO), 64'(0));
      checkRegs("reset");

      readReg(8'h08, 3'b001, 2'b00, 32'h0000_0000);
      drainResponses();

      applyStimulus(8'h04, 32'hDEAD_BEEF, 4'hF, 3'b001, 2'b00);
      model[1] = 32'hDEAD_BEEF;
      checkOutput("reg1AfterWrite", 64'(regsO[63:32]), 64'(32'hDEAD_BEEF));
      checkOutput("pulseReg1", 64'(wrPulseO), 64'(16'h0002));
      @(posedge aclk); #1;
      checkOutput("pulseReg1Gone", 64'(wrPulseO), 64'(0));
      drainResponses();
      readReg(8'h04, 3'b001, 2'b00, 32'hDEAD_BEEF);
      drainResponses();
      readReg(8'h07, 3'b001, 2'b00, 32'hDEAD_BEEF);
      drainResponses();

      applyStimulus(8'h0C, 32'hFFFF_FFFF, 4'hF, 3'b001, 2'b00);
      drainResponses();
      expB.push_back(2'b00);
      sendW(32'h1234_5678, 4'b0101);
      checkOutput("wFirstWready", 64'({bus.wready, bus.awready}), 64'(2'b01));
      repeat (3) begin
         @(posedge aclk); #1;
         checkOutput("wFirstWaiting", 64'({bus.wready, bus.bvalid}), 64'(2'b00));
      end
      sendAw(8'h0C, 3'b001);
      model[3] = 32'hFF34_FF78;
      checkOutput("reg3Merged", 64'(regsO[127:96]), 64'(32'hFF34_FF78));
      drainResponses();
      readReg(8'h0C, 3'b001, 2'b00, 32'hFF34_FF78);
      drainResponses();

      applyStimulus(8'h40, 32'hAAAA_AAAA, 4'hF, 3'b001, 2'b10);
      checkOutput("oorPulse", 64'(wrPulseO), 64'(0));
      checkRegs("oorWrite");
      drainResponses();
      readReg(8'h40, 3'b001, 2'b10, 32'h0000_0000);
      drainResponses();

      applyStimulus(8'h3C, 32'hCAFE_F00D, 4'hF, 3'b001, 2'b00);
      model[15] = 32'hCAFE_F00D;
      checkOutput("pulseReg15", 64'(wrPulseO), 64'(16'h8000));
      drainResponses();
      applyStimulus(8'h04, 32'h1111_1111, 4'h0, 3'b001, 2'b00);
      checkOutput("zeroStrbPulse", 64'(wrPulseO), 64'(16'h0002));
      checkRegs("zeroStrb");
      drainResponses();

      fork
         applyStimulus(8'h3C, 32'h5555_5555, 4'hF, 3'b001, 2'b00);
         readReg(8'h3C, 3'b001, 2'b00, 32'hCAFE_F00D);
      join
      model[15] = 32'h5555_5555;
      drainResponses();

      bus.bready = 1'b0;
      applyStimulus(8'h08, 32'h0BAD_F00D, 4'hF, 3'b001, 2'b00);
      model[2] = 32'h0BAD_F00D;
      repeat (5) begin
         @(negedge aclk);
         checkOutput("bStall", 64'({bus.bvalid, bus.bresp, bus.awready, bus.wready}), 64'(5'b1_00_00));
      end
      @(posedge aclk); #1;
      bus.bready = 1'b1;
      drainResponses();
      bus.rready = 1'b0;
      readReg(8'h08, 3'b001, 2'b00, 32'h0BAD_F00D);
      repeat (5) begin
         @(negedge aclk);
         checkOutput("rStallCtl", 64'({bus.rvalid, bus.rresp, bus.arready}), 64'(4'b1_00_0));
         checkOutput("rStallData", 64'(bus.rdata), 64'(32'h0BAD_F00D));
      end
      @(posedge aclk); #1;
      bus.rready = 1'b1;
      drainResponses();

`ifdef AXI_LITE_REGFILE_PROT_CHECK_EN
      applyStimulus(8'h04, 32'h9999_9999, 4'hF, 3'b000, 2'b10);
      checkOutput("unprivPulse", 64'(wrPulseO), 64'(0));
      checkRegs("unprivWrite");
      drainResponses();
      readReg(8'h04, 3'b000, 2'b10, 32'h0000_0000);
      drainResponses();
`else
      applyStimulus(8'h04, 32'h9999_9999, 4'hF, 3'b000, 2'b00);
      model[1] = 32'h9999_9999;
      checkOutput("protIgnoredPulse", 64'(wrPulseO), 64'(16'h0002));
      checkRegs("protIgnored");
      drainResponses();
      readReg(8'h04, 3'b000, 2'b00, 32'h9999_9999);
      drainResponses();
`endif

      bus.bready = 1'b0;
      bus.rready = 1'b0;
      fork
         sendAw(8'h10, 3'b001);
         sendW(32'h1111_2222, 4'hF);
         sendAr(8'h04, 3'b001);
      join
      checkOutput("preResetValids", 64'({bus.bvalid, bus.rvalid}), 64'(2'b11));
      aresetn = 1'b0;
      @(posedge aclk); #1;
      aresetn = 1'b1;
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
      checkOutput("midResetValids", 64'({bus.bvalid, bus.rvalid}), 64'(2'b00));
      checkOutput("midResetReadies", 64'({bus.awready, bus.wready, bus.arready}), 64'(3'b111));
      checkOutput("midResetPulse", 64'(wrPulseO), 64'(0));
      checkRegs("midReset");
      bus.bready = 1'b1;
      bus.rready = 1'b1;

      readReg(8'h04, 3'b001, 2'b00, 32'h0000_0000);
      drainResponses();
      repeat (3) @(posedge aclk);
      #1;

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
